fwd_hazard_unit: RTL and testbench

Parametrised forwarding and hazard unit for the pipelined datapath; successor to the fixed two-source MEM/WB forwarder. It resolves NSRC execute-stage source operands against NFWD downstream stages with youngest-first priority. It raises a stall for not-yet-ready results and for registers owned by an outstanding long-latency op, tracked in an internal scoreboard. It holds forwarded operands across stall cycles so a result draining out of the pipeline is not lost.

---
 rtl/fwd_hazard_unit_if.sv | 40 ++++
 rtl/fwd_hazard_unit.sv | 133 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_if.sv
// Bus between the EX stage, the forwarding network and the hazard unit.
// The master side is the pipeline; the slave side is fwd_hazard_unit.
interface fwd_hazard_unit_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NSRC    = 2,
  parameter int NFWD    = 2,
  parameter int MAXPEND = 4
);
  localparam int CW = $clog2(MAXPEND + 1);

  logic [NSRC*REG_AW-1:0] ex_src;
  logic [NSRC*DATA_W-1:0] ex_rdat;
  logic                   ex_hold;
  logic [NFWD-1:0]        fwd_wen;
  logic [NFWD*REG_AW-1:0] fwd_dest;
  logic [NFWD*DATA_W-1:0] fwd_data;
  logic [NFWD-1:0]        fwd_rdy;
  logic                   lo_issue;
  logic [REG_AW-1:0]      lo_dest;
  logic                   lo_done;
  logic [REG_AW-1:0]      lo_done_dest;
  logic [NSRC*DATA_W-1:0] ex_opnd;
  logic [NSRC-1:0]        fwd_hit;
  logic                   hz_stall;
  logic                   lo_ready;
  logic [CW-1:0]          pend_cnt;

  modport master (
    output ex_src, ex_rdat, ex_hold, fwd_wen, fwd_dest, fwd_data, fwd_rdy,
    output lo_issue, lo_dest, lo_done, lo_done_dest,
    input  ex_opnd, fwd_hit, hz_stall, lo_ready, pend_cnt
  );

  modport slave (
    input  ex_src, ex_rdat, ex_hold, fwd_wen, fwd_dest, fwd_data, fwd_rdy,
    input  lo_issue, lo_dest, lo_done, lo_done_dest,
    output ex_opnd, fwd_hit, hz_stall, lo_ready, pend_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding with youngest-first priority, load-use and long-latency
// scoreboard stalls, and per-source hold registers that survive stall cycles.
module fwd_hazard_unit #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NSRC    = 2,
  parameter int NFWD    = 2,
  parameter int MAXPEND = 4
) (
  input  logic             CLK,
  input  logic             RST,
  fwd_hazard_unit_if.slave bus
);
  localparam int CW   = $clog2(MAXPEND + 1);
  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0]   r_pend;
  logic [CW-1:0]     r_pend_cnt;
  logic [NSRC-1:0]   r_hold_vld;
  logic [DATA_W-1:0] r_hold_data [NSRC];

  logic [REG_AW-1:0] w_src [NSRC];
  logic [DATA_W-1:0] w_sel [NSRC];
  logic [NSRC-1:0]   w_match;
  logic [NSRC-1:0]   w_rdy;
  logic [NSRC-1:0]   w_pend_hit;
  logic              w_stall;
  logic              w_stalled;
  logic              w_lo_ready;
  logic              w_issue;
  logic              w_done;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    assign w_src[k] = bus.ex_src[k*REG_AW +: REG_AW];
  end

  // Scan oldest to youngest so the youngest matching stage is the one kept.
  always_comb begin
    for (int k = 0; k < NSRC; k++) begin
      w_match[k]    = 1'b0;
      w_rdy[k]      = 1'b0;
      w_sel[k]      = '0;
      w_pend_hit[k] = 1'b0;
      for (int j = NFWD - 1; j >= 0; j--) begin
        if (bus.fwd_wen[j] && (bus.fwd_dest[j*REG_AW +: REG_AW] != '0) &&
            (bus.fwd_dest[j*REG_AW +: REG_AW] == w_src[k])) begin
          w_match[k] = 1'b1;
          w_rdy[k]   = bus.fwd_rdy[j];
          w_sel[k]   = bus.fwd_data[j*DATA_W +: DATA_W];
        end
      end
      w_pend_hit[k] = (w_src[k] != '0) && r_pend[w_src[k]];
    end
  end

  always_comb begin
    w_stall = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if ((w_match[k] && !w_rdy[k]) || w_pend_hit[k]) begin
        w_stall = 1'b1;
      end
    end
  end

  assign w_stalled = w_stall || bus.ex_hold;

  always_comb begin
    bus.ex_opnd = '0;
    bus.fwd_hit = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (w_match[k]) begin
        bus.ex_opnd[k*DATA_W +: DATA_W] = w_sel[k];
        bus.fwd_hit[k]                  = 1'b1;
      end else if (r_hold_vld[k] && (w_src[k] != '0)) begin
        bus.ex_opnd[k*DATA_W +: DATA_W] = r_hold_data[k];
        bus.fwd_hit[k]                  = 1'b1;
      end else begin
        bus.ex_opnd[k*DATA_W +: DATA_W] = bus.ex_rdat[k*DATA_W +: DATA_W];
      end
    end
  end

  // A completion in the same cycle frees both a counter slot and a busy dest.
  assign w_lo_ready = ((r_pend_cnt < CW'(MAXPEND)) || bus.lo_done) &&
                      (!r_pend[bus.lo_dest] ||
                       (bus.lo_done && (bus.lo_done_dest == bus.lo_dest))) &&
                      (bus.lo_dest != '0);
  assign w_issue    = bus.lo_issue && w_lo_ready;
  assign w_done     = bus.lo_done && r_pend[bus.lo_done_dest];

  assign bus.hz_stall = w_stall;
  assign bus.lo_ready = w_lo_ready;
  assign bus.pend_cnt = r_pend_cnt;

  // Set is applied after clear so a same-register issue/done leaves it pending.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      if (w_done) begin
        r_pend[bus.lo_done_dest] <= 1'b0;
      end
      if (w_issue) begin
        r_pend[bus.lo_dest] <= 1'b1;
      end
      if (w_issue && !w_done) begin
        r_pend_cnt <= r_pend_cnt + CW'(1);
      end else if (!w_issue && w_done) begin
        r_pend_cnt <= r_pend_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hold_vld <= '0;
      for (int k = 0; k < NSRC; k++) begin
        r_hold_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSRC; k++) begin
        if (!w_stalled) begin
          r_hold_vld[k] <= 1'b0;
        end else if (w_match[k] && w_rdy[k]) begin
          r_hold_vld[k]  <= 1'b1;
          r_hold_data[k] <= w_sel[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and randomized bench for fwd_hazard_unit, checked against a
// queue-based model of the pending set and per-source hold state.
module tb_fwd_hazard_unit;
  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int NSRC    = 2;
  localparam int NFWD    = 2;
  localparam int MAXPEND = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  fwd_hazard_unit_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NSRC(NSRC),
                       .NFWD(NFWD), .MAXPEND(MAXPEND)) bus ();

  fwd_hazard_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NSRC(NSRC),
                    .NFWD(NFWD), .MAXPEND(MAXPEND)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus shadow
  logic [REG_AW-1:0] src  [NSRC];
  logic [DATA_W-1:0] rdat [NSRC];
  bit                hold;
  bit                wen  [NFWD];
  logic [REG_AW-1:0] dest [NFWD];
  logic [DATA_W-1:0] data [NFWD];
  bit                rdy  [NFWD];
  bit                iss;
  logic [REG_AW-1:0] ld;
  bit                dn;
  logic [REG_AW-1:0] dd;

  // Reference model state and per-cycle expectations
  int                pq[$];
  logic [DATA_W-1:0] m_hold [NSRC];
  bit                m_hvld [NSRC];
  logic [DATA_W-1:0] e_op   [NSRC];
  bit                e_opchk[NSRC];
  bit                e_hit  [NSRC];
  bit                e_capt [NSRC];
  bit                e_stall;
  bit                e_ready;
  int                e_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_pend(input int r);
    foreach (pq[i]) if (pq[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    for (int k = 0; k < NSRC; k++) begin src[k] = '0; rdat[k] = '0; end
    for (int j = 0; j < NFWD; j++) begin wen[j] = 0; dest[j] = '0; data[j] = '0; rdy[j] = 0; end
    hold = 0; iss = 0; ld = '0; dn = 0; dd = '0;
  endtask

  task automatic apply();
    for (int k = 0; k < NSRC; k++) begin
      bus.ex_src[k*REG_AW +: REG_AW]  = src[k];
      bus.ex_rdat[k*DATA_W +: DATA_W] = rdat[k];
    end
    for (int j = 0; j < NFWD; j++) begin
      bus.fwd_wen[j]                   = wen[j];
      bus.fwd_dest[j*REG_AW +: REG_AW] = dest[j];
      bus.fwd_data[j*DATA_W +: DATA_W] = data[j];
      bus.fwd_rdy[j]                   = rdy[j];
    end
    bus.ex_hold      = hold;
    bus.lo_issue     = iss;
    bus.lo_dest      = ld;
    bus.lo_done      = dn;
    bus.lo_done_dest = dd;
  endtask

  task automatic compute();
    int found;
    e_stall = 0;
    for (int k = 0; k < NSRC; k++) begin
      e_op[k] = rdat[k]; e_opchk[k] = 1; e_hit[k] = 0; e_capt[k] = 0;
      found = -1;
      if (src[k] != 0) begin
        for (int j = 0; j < NFWD; j++)
          if (found < 0 && wen[j] && dest[j] == src[k]) found = j;
        if (found >= 0) begin
          e_hit[k] = 1;
          if (rdy[found]) begin e_op[k] = data[found]; e_capt[k] = 1; end
          else begin e_stall = 1; e_opchk[k] = 0; end
        end else if (m_hvld[k]) begin
          e_op[k] = m_hold[k]; e_hit[k] = 1;
        end
        if (is_pend(int'(src[k]))) e_stall = 1;
      end
    end
    e_ready = ((pq.size() < MAXPEND) || dn) &&
              (!is_pend(int'(ld)) || (dn && dd == ld)) && (ld != 0);
    e_cnt = pq.size();
  endtask

  task automatic update();
    bit stalled;
    stalled = e_stall || hold;
    for (int k = 0; k < NSRC; k++) begin
      if (!stalled) m_hvld[k] = 0;
      else if (e_capt[k]) begin m_hold[k] = e_op[k]; m_hvld[k] = 1; end
    end
    if (dn)
      for (int i = 0; i < pq.size(); i++)
        if (pq[i] == int'(dd)) begin pq.delete(i); break; end
    if (iss && e_ready && !is_pend(int'(ld))) pq.push_back(int'(ld));
  endtask

  task automatic check_all();
    for (int k = 0; k < NSRC; k++) begin
      if (e_opchk[k]) chk($sformatf("opnd%0d", k), bus.ex_opnd[k*DATA_W +: DATA_W], e_op[k]);
      chk($sformatf("hit%0d", k), bus.fwd_hit[k], e_hit[k]);
    end
    chk("hz_stall", bus.hz_stall, e_stall);
    chk("lo_ready", bus.lo_ready, e_ready);
    chk("pend_cnt", bus.pend_cnt, e_cnt);
  endtask

  // drive: inputs settle then expectations formed; commit: compare and clock
  task automatic drive();
    apply(); #4; compute();
  endtask

  task automatic commit();
    check_all(); @(posedge CLK); update(); #1;
  endtask

  task automatic model_clear();
    pq.delete();
    for (int k = 0; k < NSRC; k++) begin m_hvld[k] = 0; m_hold[k] = '0; end
  endtask

  initial begin
    idle(); model_clear(); apply();
    #1; compute(); check_all();
    chk("rst_cnt", bus.pend_cnt, 0);
    @(posedge CLK); #1; RST = 1'b0;

    // Youngest stage wins; dest 0 never forwards
    idle(); rdat[0] = 32'h1111;
    wen[0] = 1; dest[0] = 3; data[0] = 32'hAAAA; rdy[0] = 1;
    wen[1] = 1; dest[1] = 3; data[1] = 32'hBBBB; rdy[1] = 1;
    src[0] = 3;
    drive();
    chk("prio_op0", bus.ex_opnd[0 +: DATA_W], 32'hAAAA);
    chk("prio_hit0", bus.fwd_hit[0], 1);
    commit();
    dest[0] = 0; dest[1] = 0;
    drive();
    chk("zero_op0", bus.ex_opnd[0 +: DATA_W], 32'h1111);
    chk("zero_hit0", bus.fwd_hit[0], 0);
    commit();

    // Load-use: one stall, then forward from stage 1
    idle(); src[1] = 5; rdat[1] = 32'h7777;
    wen[0] = 1; dest[0] = 5; rdy[0] = 0;
    drive(); chk("lu_stall", bus.hz_stall, 1); commit();
    wen[0] = 0; wen[1] = 1; dest[1] = 5; data[1] = 32'h1234; rdy[1] = 1;
    drive();
    chk("lu_op1", bus.ex_opnd[DATA_W +: DATA_W], 32'h1234);
    chk("lu_stall2", bus.hz_stall, 0);
    commit();

    // External hold keeps a forwarded value after the stage drains
    idle(); src[0] = 7; rdat[0] = 32'h5555; hold = 1;
    wen[1] = 1; dest[1] = 7; data[1] = 32'hCAFE; rdy[1] = 1;
    drive(); commit();
    wen[1] = 0;
    for (int c = 0; c < 2; c++) begin
      drive(); chk("hold_op0", bus.ex_opnd[0 +: DATA_W], 32'hCAFE); commit();
    end
    hold = 0;
    drive(); chk("rel_op0", bus.ex_opnd[0 +: DATA_W], 32'hCAFE); commit();
    drive();
    chk("post_op0", bus.ex_opnd[0 +: DATA_W], 32'h5555);
    chk("post_hit0", bus.fwd_hit[0], 0);
    commit();

    // Fill the scoreboard, overflow issue is ignored
    idle();
    for (int r = 8; r < 12; r++) begin iss = 1; ld = REG_AW'(r); drive(); commit(); end
    ld = 12; drive();
    chk("full_ready", bus.lo_ready, 0);
    chk("full_cnt", bus.pend_cnt, 4);
    commit();
    iss = 0; src[0] = 9;
    drive(); chk("r9_stall", bus.hz_stall, 1); chk("r12_cnt", bus.pend_cnt, 4); commit();
    dn = 1; dd = 9;
    drive(); chk("r9_done_stall", bus.hz_stall, 1); commit();
    dn = 0;
    drive(); chk("r9_free", bus.hz_stall, 0); chk("cnt3", bus.pend_cnt, 3); commit();
    src[0] = 0; iss = 1; ld = 9; drive(); commit();

    // Same-cycle issue and completion on one register
    ld = 8; dn = 1; dd = 8;
    drive(); chk("same_ready", bus.lo_ready, 1); commit();
    iss = 0; dn = 0; src[0] = 8;
    drive(); chk("same_stall", bus.hz_stall, 1); chk("same_cnt", bus.pend_cnt, 4); commit();
    src[0] = 0; dn = 1; dd = 9; drive(); commit();
    dd = 10; drive(); commit();
    dn = 0;

    // Reset with two pending ops and a live hold
    src[0] = 7; rdat[0] = 32'h4242; src[1] = 8; rdat[1] = 32'h3131; hold = 1;
    wen[1] = 1; dest[1] = 7; data[1] = 32'hBEEF; rdy[1] = 1;
    drive(); chk("pre_rst_cnt", bus.pend_cnt, 2); commit();
    #1; RST = 1'b1; wen[1] = 0; hold = 0; apply(); model_clear();
    #1; compute(); check_all();
    chk("rst_mid_cnt", bus.pend_cnt, 0);
    @(posedge CLK); #1; RST = 1'b0;
    drive();
    chk("after_rst_stall", bus.hz_stall, 0);
    chk("after_rst_op0", bus.ex_opnd[0 +: DATA_W], 32'h4242);
    chk("after_rst_hit0", bus.fwd_hit[0], 0);
    commit();

    // Randomized traffic on a small register window to force collisions
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NSRC; k++) begin
        src[k]  = REG_AW'($urandom_range(0, 7));
        rdat[k] = $urandom;
      end
      for (int j = 0; j < NFWD; j++) begin
        wen[j]  = ($urandom_range(0, 2) != 0);
        dest[j] = REG_AW'($urandom_range(0, 7));
        data[j] = $urandom;
        rdy[j]  = (j != 0) || ($urandom_range(0, 3) != 0);
      end
      hold = ($urandom_range(0, 3) == 0);
      iss  = ($urandom_range(0, 2) == 0);
      ld   = REG_AW'($urandom_range(0, 7));
      dn   = ($urandom_range(0, 3) == 0);
      if (pq.size() > 0 && $urandom_range(0, 3) != 0)
        dd = REG_AW'(pq[$urandom_range(0, pq.size() - 1)]);
      else
        dd = REG_AW'($urandom_range(0, 7));
      if (pq.size() >= MAXPEND && dn && !is_pend(int'(dd))) dn = 0;
      drive(); commit();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
